// File: rtl/bp_fe_pkg.sv
// Front-end shared types: fetch-buffer entry kinds, buffer FSM states and the entry struct macro.
`define BP_FE_DECLARE_FETCH_BUF_ENTRY_S(vaddr_width_mp, instr_width_mp) \
  typedef struct packed {                                                 \
    logic [vaddr_width_mp-1:0]         pc;                                \
    bp_fe_pkg::bp_fe_fetch_buf_kind_e  kind;                              \
    logic [instr_width_mp-1:0]         data;                              \
  } bp_fe_fetch_buf_entry_s

`define BP_FE_FETCH_BUF_ENTRY_WIDTH(vaddr_width_mp, instr_width_mp) \
  ((vaddr_width_mp) + 3 + (instr_width_mp))

package bp_fe_pkg;

  typedef enum logic [2:0] {
    e_fb_instr        = 3'd0,
    e_fb_access_fault = 3'd1,
    e_fb_page_fault   = 3'd2,
    e_fb_itlb_miss    = 3'd3,
    e_fb_icache_miss  = 3'd4
  } bp_fe_fetch_buf_kind_e;

  typedef enum logic {
    e_run  = 1'b0,
    e_hold = 1'b1
  } bp_fe_fetch_buf_state_e;

  // Faults outrank misses; only a clean response is an instruction.
  function automatic bp_fe_fetch_buf_kind_e bp_fe_fetch_buf_kind(
    input logic access_fault,
    input logic page_fault,
    input logic itlb_miss,
    input logic icache_miss
  );
    if (access_fault)     return e_fb_access_fault;
    else if (page_fault)  return e_fb_page_fault;
    else if (itlb_miss)   return e_fb_itlb_miss;
    else if (icache_miss) return e_fb_icache_miss;
    else                  return e_fb_instr;
  endfunction

endpackage

// File: rtl/bp_fe_fetch_buffer_inflight.sv
// bp_fe_fetch_inflight: two-stage PC pipeline tracking fetches whose responses are still pending.
module bp_fe_fetch_inflight
  #(parameter int vaddr_width_p = 39)
  (input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     fetch_v_i,
   input  logic [vaddr_width_p-1:0] fetch_vaddr_i,
   input  logic                     poison_i,
   input  logic                     flush_i,
   output logic                     s2_v_o,
   output logic [vaddr_width_p-1:0] s2_pc_o,
   output logic [1:0]               inflight_cnt_o);

  logic                     s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [vaddr_width_p-1:0] s1_pc_q, s1_pc_d, s2_pc_q, s2_pc_d;

  // A fetch taken during a flush is the first post-redirect fetch, so s1 always loads.
  always_comb begin
    s1_v_d  = fetch_v_i;
    s1_pc_d = fetch_vaddr_i;
    s2_v_d  = s1_v_q & ~poison_i & ~flush_i;
    s2_pc_d = s1_pc_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v_q  <= 1'b0;
      s1_pc_q <= '0;
      s2_v_q  <= 1'b0;
      s2_pc_q <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_pc_q <= s1_pc_d;
      s2_v_q  <= s2_v_d;
      s2_pc_q <= s2_pc_d;
    end
  end

  assign s2_v_o         = s2_v_q;
  assign s2_pc_o        = s2_pc_q;
  assign inflight_cnt_o = {1'b0, s1_v_q} + {1'b0, s2_v_q};

endmodule

// File: rtl/bp_fe_fetch_buffer.sv
// Fetch buffer: pairs in-flight PCs with non-stallable responses and issues fetch credits.
// Optional BP_FE_FETCH_BUF_BYPASS_EN forwards a response straight to the head when the buffer is empty.
module bp_fe_fetch_buffer
  import bp_fe_pkg::*;
  #(parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int els_p         = 4)
  (input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     fetch_v_i,
   input  logic [vaddr_width_p-1:0] fetch_vaddr_i,
   output logic                     fetch_credit_o,
   input  logic                     poison_i,
   input  logic                     flush_i,
   input  logic                     resp_v_i,
   input  logic                     resp_access_fault_i,
   input  logic                     resp_page_fault_i,
   input  logic                     resp_itlb_miss_i,
   input  logic                     resp_icache_miss_i,
   input  logic [instr_width_p-1:0] resp_data_i,
   output logic                     v_o,
   input  logic                     yumi_i,
   output logic [vaddr_width_p-1:0] pc_o,
   output logic [instr_width_p-1:0] instr_o,
   output logic [2:0]               kind_o);

  `BP_FE_DECLARE_FETCH_BUF_ENTRY_S(vaddr_width_p, instr_width_p);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam int sum_w_lp = ptr_w_lp + 2;

  logic                     s2_v;
  logic [vaddr_width_p-1:0] s2_pc;
  logic [1:0]               inflight_cnt;

  bp_fe_fetch_inflight #(.vaddr_width_p(vaddr_width_p)) u_inflight
    (.clk_i          (clk_i),
     .reset_n_i      (reset_n_i),
     .fetch_v_i      (fetch_v_i),
     .fetch_vaddr_i  (fetch_vaddr_i),
     .poison_i       (poison_i),
     .flush_i        (flush_i),
     .s2_v_o         (s2_v),
     .s2_pc_o        (s2_pc),
     .inflight_cnt_o (inflight_cnt));

  bp_fe_fetch_buf_state_e  state_q, state_d;
  logic [cnt_w_lp-1:0]     count_q, count_d;
  logic [ptr_w_lp-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  bp_fe_fetch_buf_entry_s  mem_q [els_p];
  bp_fe_fetch_buf_entry_s  mem_d [els_p];
  bp_fe_fetch_buf_entry_s  resp_entry, head_entry;
  bp_fe_fetch_buf_kind_e   resp_kind;
  logic                    run, enq, wr, rd, empty, bypass;
  logic [sum_w_lp-1:0]     credit_sum;

  always_comb begin
    resp_kind       = bp_fe_fetch_buf_kind(resp_access_fault_i, resp_page_fault_i,
                                           resp_itlb_miss_i, resp_icache_miss_i);
    resp_entry.pc   = s2_pc;
    resp_entry.kind = resp_kind;
    resp_entry.data = (resp_kind == e_fb_instr) ? resp_data_i : '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= e_run;
    else            state_q <= state_d;
  end

  // Any accepted non-instruction response parks the front end until a redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_run:   if (flush_i) state_d = e_run;
               else if (enq && (resp_kind != e_fb_instr)) state_d = e_hold;
      e_hold:  if (flush_i) state_d = e_run;
      default: state_d = e_run;
    endcase
  end

  // Credit counts buffered plus in-flight entries so a response always has a slot.
  always_comb begin
    run            = (state_q == e_run);
    credit_sum     = sum_w_lp'(count_q) + sum_w_lp'(inflight_cnt);
    fetch_credit_o = run & ~flush_i & (credit_sum < sum_w_lp'(els_p));
  end

  assign empty = (count_q == '0);
  assign enq   = resp_v_i & run & ~flush_i;

`ifdef BP_FE_FETCH_BUF_BYPASS_EN
  assign bypass = enq & empty;
  always_comb begin
    head_entry = mem_q[rptr_q];
    if (bypass) head_entry = resp_entry;
  end
`else
  assign bypass     = 1'b0;
  assign head_entry = mem_q[rptr_q];
`endif

  assign wr = enq & ~(bypass & yumi_i);
  assign rd = yumi_i & ~empty & ~flush_i;

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    mem_d   = mem_q;
    if (flush_i) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (wr) begin
        mem_d[wptr_q] = resp_entry;
        wptr_d        = wptr_q + ptr_w_lp'(1);
      end
      if (rd) rptr_d = rptr_q + ptr_w_lp'(1);
      if (wr && !rd)      count_d = count_q + cnt_w_lp'(1);
      else if (!wr && rd) count_d = count_q - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    v_o     = ~empty | bypass;
    pc_o    = v_o ? head_entry.pc   : '0;
    instr_o = v_o ? head_entry.data : '0;
    kind_o  = v_o ? head_entry.kind : e_fb_instr;
  end

  a_resp_matches_inflight: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    resp_v_i == s2_v) else $error("resp_v_i disagrees with in-flight fetch");
  a_fetch_has_credit: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(fetch_v_i && !flush_i && !fetch_credit_o)) else $error("fetch accepted without credit");
  a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(wr && (count_q == cnt_w_lp'(els_p)))) else $error("enqueue into full fetch buffer");

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Directed bench for bp_fe_fetch_buffer; expectations follow BP_FE_FETCH_BUF_BYPASS_EN when defined.
module tb_bp_fe_fetch_buffer;
  import bp_fe_pkg::*;

  localparam int VW  = 39;
  localparam int IW  = 32;
  localparam int ELS = 4;
`ifdef BP_FE_FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          fetch_v_i, fetch_credit_o, poison_i, flush_i;
  logic [VW-1:0] fetch_vaddr_i, pc_o;
  logic          resp_v_i, resp_access_fault_i, resp_page_fault_i;
  logic          resp_itlb_miss_i, resp_icache_miss_i;
  logic [IW-1:0] resp_data_i, instr_o;
  logic          v_o, yumi_i;
  logic [2:0]    kind_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  bp_fe_fetch_buffer #(.vaddr_width_p(VW), .instr_width_p(IW), .els_p(ELS)) dut
    (.clk_i               (clk_i),
     .reset_n_i           (reset_n_i),
     .fetch_v_i           (fetch_v_i),
     .fetch_vaddr_i       (fetch_vaddr_i),
     .fetch_credit_o      (fetch_credit_o),
     .poison_i            (poison_i),
     .flush_i             (flush_i),
     .resp_v_i            (resp_v_i),
     .resp_access_fault_i (resp_access_fault_i),
     .resp_page_fault_i   (resp_page_fault_i),
     .resp_itlb_miss_i    (resp_itlb_miss_i),
     .resp_icache_miss_i  (resp_icache_miss_i),
     .resp_data_i         (resp_data_i),
     .v_o                 (v_o),
     .yumi_i              (yumi_i),
     .pc_o                (pc_o),
     .instr_o             (instr_o),
     .kind_o              (kind_o));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic [VW-1:0] pc,
                      input logic [IW-1:0] instr, input logic [2:0] kind);
    chk({tag, "_v"},     v_o,     1'b1);
    chk({tag, "_pc"},    pc_o,    pc);
    chk({tag, "_instr"}, instr_o, instr);
    chk({tag, "_kind"},  kind_o,  kind);
  endtask

  task automatic idle();
    fetch_v_i = 0; fetch_vaddr_i = '0; poison_i = 0; flush_i = 0; yumi_i = 0;
    resp_v_i = 0; resp_access_fault_i = 0; resp_page_fault_i = 0;
    resp_itlb_miss_i = 0; resp_icache_miss_i = 0; resp_data_i = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic fetch(input logic [VW-1:0] pc);
    fetch_v_i = 1; fetch_vaddr_i = pc;
  endtask

  task automatic resp(input logic [IW-1:0] d, input logic af, input logic pf,
                      input logic itlb, input logic ic);
    resp_v_i = 1; resp_data_i = d; resp_access_fault_i = af;
    resp_page_fault_i = pf; resp_itlb_miss_i = itlb; resp_icache_miss_i = ic;
  endtask

  localparam logic [VW-1:0] PC0 = 39'h00_8000_0000;

  initial begin
    idle();
    reset_n_i = 1'b1;
    #2 reset_n_i = 1'b0;
    #1;
    chk("rst_v", v_o, 1'b0);
    chk("rst_credit", fetch_credit_o, 1'b1);
    chk("rst_pc", pc_o, '0);
    chk("rst_kind", kind_o, 3'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) reset_n_i = 1'b1;
    tick();

    // Four back-to-back fetches fill the buffer, then two dequeues around a poisoned fetch
    fetch(PC0);        #1; chk("t2_c0_credit", fetch_credit_o, 1'b1); tick();
    fetch(PC0 + 4);    #1; tick();
    fetch(PC0 + 8);    resp(32'h1000_0013, 0, 0, 0, 0); #1;
    chk("t2_c2_v", v_o, BYP); tick();
    fetch(PC0 + 12);   resp(32'h1100_0013, 0, 0, 0, 0); #1;
    chk("t2_c3_credit", fetch_credit_o, 1'b1); tick();
    resp(32'h1200_0013, 0, 0, 0, 0); #1;
    chk("t2_c4_credit", fetch_credit_o, 1'b0); tick();
    resp(32'h1300_0013, 0, 0, 0, 0); #1;
    chk("t2_c5_credit", fetch_credit_o, 1'b0); tick();
    #1; chk("t2_c6_credit", fetch_credit_o, 1'b0);
    head("t2_e0", PC0, 32'h1000_0013, e_fb_instr); yumi_i = 1; tick();

    fetch(39'h100); #1; chk("t3_p0_credit", fetch_credit_o, 1'b1);
    head("t2_e1a", PC0 + 4, 32'h1100_0013, e_fb_instr); tick();
    poison_i = 1; #1; chk("t3_p1_credit", fetch_credit_o, 1'b0); tick();
    #1; chk("t3_p2_credit", fetch_credit_o, 1'b1); tick();
    #1; head("t2_e1", PC0 + 4,  32'h1100_0013, e_fb_instr); yumi_i = 1; tick();
    #1; head("t2_e2", PC0 + 8,  32'h1200_0013, e_fb_instr); yumi_i = 1; tick();
    #1; head("t2_e3", PC0 + 12, 32'h1300_0013, e_fb_instr); yumi_i = 1; tick();
    #1; chk("t3_empty_v", v_o, 1'b0); chk("t3_empty_credit", fetch_credit_o, 1'b1); tick();

    // Miss stops the front end; later response dropped until flush
    fetch(39'h200); tick();
    fetch(39'h204); tick();
    fetch(39'h208); resp(32'h2000_0013, 0, 0, 0, 0); tick();
    resp(32'h2100_0013, 0, 0, 0, 1); #1; chk("t4_d3_credit", fetch_credit_o, 1'b1); tick();
    resp(32'h2200_0013, 0, 0, 0, 0); #1; chk("t4_d4_credit", fetch_credit_o, 1'b0); tick();
    #1; chk("t4_d5_credit", fetch_credit_o, 1'b0);
    head("t4_e0", 39'h200, 32'h2000_0013, e_fb_instr); yumi_i = 1; tick();
    #1; head("t4_e1", 39'h204, 32'h0, e_fb_icache_miss); yumi_i = 1; tick();
    #1; chk("t4_drop_v", v_o, 1'b0); chk("t4_hold_credit", fetch_credit_o, 1'b0); tick();
    flush_i = 1; #1; chk("t4_flush_credit", fetch_credit_o, 1'b0); tick();
    #1; chk("t4_run_credit", fetch_credit_o, 1'b1); tick();

    // Flush with a same-cycle fetch while 2 buffered and 1 in flight; yumi ignored
    fetch(39'h300); tick();
    fetch(39'h304); tick();
    fetch(39'h308); resp(32'h3000_0013, 0, 0, 0, 0); tick();
    resp(32'h3100_0013, 0, 0, 0, 0); tick();
    flush_i = 1; fetch(39'h400); resp(32'h3200_0013, 0, 0, 0, 0); yumi_i = 1; #1;
    chk("t5_flush_credit", fetch_credit_o, 1'b0); chk("t5_pre_v", v_o, 1'b1); tick();
    #1; chk("t5_post_v", v_o, 1'b0); chk("t5_post_credit", fetch_credit_o, 1'b1); tick();
    resp(32'h4000_0013, 0, 0, 0, 0); #1; chk("t5_resp_v", v_o, BYP); tick();
    #1; head("t5_e0", 39'h400, 32'h4000_0013, e_fb_instr); yumi_i = 1; tick();
    #1; chk("t5_end_v", v_o, 1'b0); tick();

    // Access fault outranks ITLB miss; instruction forced to zero
    fetch(39'h500); tick();
    tick();
    resp(32'hDEAD_BEEF, 1, 0, 1, 0); #1;
    chk("t6_byp_v", v_o, BYP);
    chk("t6_byp_kind", kind_o, BYP ? 3'd1 : 3'd0);
    chk("t6_byp_instr", instr_o, '0);
    tick();
    #1; head("t6_e0", 39'h500, 32'h0, e_fb_access_fault);
    chk("t6_hold_credit", fetch_credit_o, 1'b0); yumi_i = 1; tick();
    #1; chk("t6_end_v", v_o, 1'b0); flush_i = 1; tick();
    #1; chk("t6_run_credit", fetch_credit_o, 1'b1); tick();

    // Asynchronous reset with three entries buffered
    fetch(39'h600); tick();
    fetch(39'h604); tick();
    fetch(39'h608); resp(32'h6000_0013, 0, 0, 0, 0); tick();
    resp(32'h6100_0013, 0, 0, 0, 0); tick();
    resp(32'h6200_0013, 0, 0, 0, 0); tick();
    #1; head("t1_pre", 39'h600, 32'h6000_0013, e_fb_instr);
    reset_n_i = 1'b0; #1;
    chk("t1_async_v", v_o, 1'b0);
    chk("t1_async_credit", fetch_credit_o, 1'b1);
    tick();
    chk("t1_next_v", v_o, 1'b0);
    chk("t1_next_credit", fetch_credit_o, 1'b1);
    chk("t1_next_pc", pc_o, '0);
    chk("t1_next_kind", kind_o, 3'd0);
    @(negedge clk_i) reset_n_i = 1'b1;
    tick();
    #1; chk("t1_rel_v", v_o, 1'b0); chk("t1_rel_credit", fetch_credit_o, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
